// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM state encoding
// and the default address/data widths.
package mem_arb_pkg;

  localparam int AW_DEF = 12;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way priority picker for the memory arbiter. Round-robin by default;
// defining MEM_ARB_FIXED_PRIO_EN removes the pointer so req0 always wins ties.
module mem_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic       pick_o
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unusedPins;

  assign unusedPins = clk ^ rst ^ update_i;
  assign pick_o     = req_i[1] & ~req_i[0];
`else
  logic favourOne_q, favourOne_d;

  // The requester that just won drops to lowest priority for the next tie.
  always_comb begin
    pick_o      = req_i[1] & (~req_i[0] | favourOne_q);
    favourOne_d = favourOne_q;
    if (update_i && (req_i != 2'b00)) begin
      favourOne_d = ~pick_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      favourOne_q <= 1'b0;
    end else begin
      favourOne_q <= favourOne_d;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory with a
// configurable read latency. Tie-break mode selected by MEM_ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          cen,
  output logic          rd,
  output logic          wr,
  output logic [AW-1:0] add,
  output logic [DW-1:0] din,
  input  logic [DW-1:0] dout
);

  state_e        state_q, state_d;
  logic          winner_q, winner_d;
  logic          we_q, we_d;
  logic [AW-1:0] add_q, add_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic          pickOne;

  mem_arb_rr uRr (
    .clk      (clk),
    .rst      (rst),
    .req_i    ({req1, req0}),
    .update_i (state_q == IDLE),
    .pick_o   (pickOne)
  );

  // The latched request doubles as the memory address/data register, so
  // add/din naturally hold their last value outside ACCESS.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    we_d      = we_q;
    add_d     = add_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          winner_d = pickOne;
          we_d     = pickOne ? we1 : we0;
          add_d    = pickOne ? addr1 : addr0;
          din_d    = pickOne ? wdata1 : wdata0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          cnt_d   = 2'(RD_LAT - 1);
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (cnt_q == 2'd0) begin
          if (winner_q) begin
            rdata1_d  = dout;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = dout;
            rvalid0_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      winner_q  <= 1'b0;
      we_q      <= 1'b0;
      add_q     <= '0;
      din_q     <= '0;
      cnt_q     <= 2'd0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      we_q      <= we_d;
      add_q     <= add_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign cen     = (state_q == ACCESS);
  assign rd      = cen & ~we_q;
  assign wr      = cen & we_q;
  assign gnt0    = cen & ~winner_q;
  assign gnt1    = cen & winner_q;
  assign add     = add_q;
  assign din     = din_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance with RD_LAT=1
// and one with RD_LAT=3, each backed by a small behavioural memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, cen, rd, wr;
  logic [7:0]  rdata0, rdata1, din, dout;
  logic [11:0] add;

  logic        lReq0, lReq1, lWe0, lWe1;
  logic [11:0] lAddr0, lAddr1;
  logic [7:0]  lWdata0, lWdata1;
  logic        lGnt0, lGnt1, lRvalid0, lRvalid1, lCen, lRd, lWr;
  logic [7:0]  lRdata0, lRdata1, lDin, lDout;
  logic [11:0] lAdd;

  int   assertCount = 0;
  int   failCount   = 0;
  logic overlapSeen = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(12), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .cen(cen), .rd(rd), .wr(wr),
    .add(add), .din(din), .dout(dout)
  );

  mem_arbiter #(.AW(12), .DW(8), .RD_LAT(3)) dutLat3 (
    .clk(clk), .rst(rst), .req0(lReq0), .req1(lReq1), .we0(lWe0), .we1(lWe1),
    .addr0(lAddr0), .addr1(lAddr1), .wdata0(lWdata0), .wdata1(lWdata1),
    .gnt0(lGnt0), .gnt1(lGnt1), .rvalid0(lRvalid0), .rvalid1(lRvalid1),
    .rdata0(lRdata0), .rdata1(lRdata1), .cen(lCen), .rd(lRd), .wr(lWr),
    .add(lAdd), .din(lDin), .dout(lDout)
  );

  // Latency-1 memory; dout is zero outside its valid cycle so a mistimed
  // capture shows up as wrong data.
  logic [7:0] memArray [0:4095];
  logic       memValid;
  logic [7:0] memData;

  always @(posedge clk) begin
    if (rst) begin
      memArray[12'hFFF] <= 8'h5C;
      memArray[12'h010] <= 8'h77;
      memValid          <= 1'b0;
    end else begin
      if (wr) memArray[add] <= din;
      memValid <= rd;
      memData  <= memArray[add];
    end
  end

  assign dout = memValid ? memData : 8'h00;

  // Latency-3 memory: returns low address byte XOR 0x3C, valid for one cycle.
  logic [2:0]  lPipeV;
  logic [23:0] lPipeD;

  always @(posedge clk) begin
    if (rst) begin
      lPipeV <= 3'b000;
    end else begin
      lPipeV <= {lPipeV[1:0], lRd};
      lPipeD <= {lPipeD[15:0], lAdd[7:0] ^ 8'h3C};
    end
  end

  assign lDout = lPipeV[2] ? lPipeD[23:16] : 8'h00;

  always @(negedge clk) begin
    if (!rst && ((gnt0 & gnt1) || (rvalid0 & rvalid1) || (rd & wr))) begin
      overlapSeen <= 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [11:0] a0,
                               input logic [7:0] d0, input logic r1, input logic w1,
                               input logic [11:0] a1, input logic [7:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int grantCount;
    int expGrant;
    int seenValid;

    rst = 1'b1;
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    lReq0 = 0; lReq1 = 0; lWe0 = 0; lWe1 = 0;
    lAddr0 = 12'h000; lAddr1 = 12'h000; lWdata0 = 8'h00; lWdata1 = 8'h00;
    repeat (3) nextCycle();

    $display("[TB] reset state");
    checkOutput("rstGnt", {30'b0, gnt1, gnt0}, 0);
    checkOutput("rstRvalid", {30'b0, rvalid1, rvalid0}, 0);
    checkOutput("rstStrobes", {29'b0, cen, rd, wr}, 0);
    checkOutput("rstAdd", add, 0);
    checkOutput("rstDin", din, 0);
    checkOutput("rstRdata", {rdata1, rdata0}, 0);
    rst = 1'b0;
    nextCycle();

    $display("[TB] req0 write 0x123 <- 0xA5");
    applyStimulus(1, 1, 12'h123, 8'hA5, 0, 0, 12'h000, 8'h00);
    nextCycle();
    checkOutput("wrGnt", {30'b0, gnt1, gnt0}, 2'b01);
    checkOutput("wrStrobes", {29'b0, cen, rd, wr}, 3'b101);
    checkOutput("wrAdd", add, 12'h123);
    checkOutput("wrDin", din, 8'hA5);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    checkOutput("wrAfterGnt", {29'b0, gnt0, cen, wr}, 0);
    checkOutput("wrAddHold", add, 12'h123);

    $display("[TB] req1 read 0x123");
    applyStimulus(0, 0, 12'h000, 8'h00, 1, 0, 12'h123, 8'h00);
    nextCycle();
    checkOutput("rdGnt", {30'b0, gnt1, gnt0}, 2'b10);
    checkOutput("rdStrobes", {29'b0, cen, rd, wr}, 3'b110);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    checkOutput("rdEarlyValid", {30'b0, rvalid1, rvalid0}, 0);
    nextCycle();
    checkOutput("rdValid", {30'b0, rvalid1, rvalid0}, 2'b10);
    checkOutput("rdData1", rdata1, 8'hA5);
    nextCycle();
    checkOutput("rdValidPulse", rvalid1, 0);
    checkOutput("rdDataHold", rdata1, 8'hA5);

    $display("[TB] both requesters held");
    applyStimulus(1, 0, 12'h000, 8'h00, 1, 0, 12'hFFF, 8'h00);
    grantCount = 0;
    for (int c = 0; c < 40 && grantCount < 4; c++) begin
      nextCycle();
      if (gnt0 || gnt1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        expGrant = 0;
`else
        expGrant = grantCount % 2;
`endif
        checkOutput($sformatf("tieGrant%0d", grantCount), {31'b0, gnt1}, expGrant);
        grantCount++;
      end
    end
    checkOutput("tieGrantCount", grantCount, 4);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    nextCycle();
`ifdef MEM_ARB_FIXED_PRIO_EN
    checkOutput("tieLastValid", {30'b0, rvalid1, rvalid0}, 2'b01);
    checkOutput("tieLastData", rdata0, 8'h00);
`else
    checkOutput("tieLastValid", {30'b0, rvalid1, rvalid0}, 2'b10);
    checkOutput("tieLastData", rdata1, 8'h5C);
`endif
    nextCycle();

    $display("[TB] req1 arrives during req0 read wait");
    applyStimulus(1, 0, 12'h123, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    checkOutput("busyGnt0", {30'b0, gnt1, gnt0}, 2'b01);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    applyStimulus(0, 0, 12'h000, 8'h00, 1, 0, 12'hFFF, 8'h00);
    checkOutput("busyNoGnt1Wait", {29'b0, gnt1, cen, rvalid0}, 0);
    nextCycle();
    checkOutput("busyRvalid0", {29'b0, gnt1, cen, rvalid0}, 3'b001);
    checkOutput("busyData0", rdata0, 8'hA5);
    nextCycle();
    checkOutput("busyGnt1", {30'b0, gnt1, gnt0}, 2'b10);
    checkOutput("busyAdd1", add, 12'hFFF);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    nextCycle();
    checkOutput("busyRvalid1", rvalid1, 1);
    checkOutput("busyData1", rdata1, 8'h5C);
    nextCycle();

    $display("[TB] reset during read wait");
    applyStimulus(1, 0, 12'h010, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    checkOutput("abortGnt", gnt0, 1);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    rst = 1'b1;
    #1;
    checkOutput("abortStrobes", {27'b0, gnt0, gnt1, cen, rd, wr}, 0);
    checkOutput("abortAddDin", {add, din}, 0);
    checkOutput("abortRdata", {rdata1, rdata0}, 0);
    nextCycle();
    rst = 1'b0;
    seenValid = 0;
    for (int c = 0; c < 4; c++) begin
      nextCycle();
      if (rvalid0 || rvalid1) seenValid++;
    end
    checkOutput("abortNoRvalid", seenValid, 0);
    applyStimulus(1, 0, 12'h010, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    checkOutput("postRstGnt", {30'b0, gnt1, gnt0}, 2'b01);
    checkOutput("postRstAdd", add, 12'h010);
    applyStimulus(0, 0, 12'h000, 8'h00, 0, 0, 12'h000, 8'h00);
    nextCycle();
    nextCycle();
    checkOutput("postRstValid", rvalid0, 1);
    checkOutput("postRstData", rdata0, 8'h77);

    $display("[TB] three-cycle read latency");
    lReq0 = 1; lWe0 = 0; lAddr0 = 12'h05A;
    nextCycle();
    checkOutput("lat3Gnt", {29'b0, lGnt0, lCen, lRd}, 3'b111);
    lReq0 = 0;
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      checkOutput($sformatf("lat3Valid%0d", k), lRvalid0, (k == 4) ? 1 : 0);
    end
    checkOutput("lat3Data", lRdata0, 8'h66);
    nextCycle();
    checkOutput("lat3ValidPulse", lRvalid0, 0);

    checkOutput("noOverlap", overlapSeen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
